// File: rtl/rgb_fade_driver_pkg.sv
// Shared definitions for the RGB fade driver: channel ordering and default sizing.
package rgb_fade_driver_pkg;

    localparam int unsigned NUM_CH           = 3;
    localparam int unsigned RGB_R            = 2;
    localparam int unsigned RGB_G            = 1;
    localparam int unsigned RGB_B            = 0;
    localparam int unsigned DEFAULT_PWM_BITS = 4;
    localparam int unsigned DEFAULT_STEP     = 1;

endpackage : rgb_fade_driver_pkg

// File: rtl/pwm_fade_channel.sv
// One LED channel: latched on/off target, duty ramp toward 0 or MAX, and PWM compare.
module pwm_fade_channel
    import rgb_fade_driver_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS,
    parameter int unsigned STEP     = DEFAULT_STEP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                capture,
    input  logic                step,
    input  logic                target_in,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                settled
);

    localparam int unsigned MAX = (1 << PWM_BITS) - 1;
    localparam int unsigned EXT = PWM_BITS + 1;

    logic                target;
    logic [EXT-1:0]      duty_ext;
    logic [EXT-1:0]      sum_ext;
    logic [PWM_BITS-1:0] duty_next;

    // Ramp one STEP toward the target level; the extra bit keeps the add from wrapping.
    always_comb begin
        duty_ext  = {1'b0, duty};
        sum_ext   = duty_ext + EXT'(STEP);
        duty_next = duty;
        if (target) begin
            duty_next = (sum_ext > EXT'(MAX)) ? PWM_BITS'(MAX) : sum_ext[PWM_BITS-1:0];
        end else begin
            duty_next = (duty_ext > EXT'(STEP)) ? PWM_BITS'(duty_ext - EXT'(STEP)) : '0;
        end
    end

    assign settled = target ? (duty == PWM_BITS'(MAX)) : (duty == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target  <= 1'b0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else if (en) begin
            if (capture) begin
                target <= target_in;
            end
            if (step) begin
                duty <= duty_next;
            end
            pwm_out <= (cnt < duty);
        end
    end

endmodule : pwm_fade_channel

// File: rtl/rgb_fade_driver.sv
// Three-channel PWM LED driver whose duties fade toward the latched RGB on/off code.
module rgb_fade_driver
    import rgb_fade_driver_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS,
    parameter int unsigned STEP     = DEFAULT_STEP
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_CH-1:0]            rgb_in,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic [NUM_CH*PWM_BITS-1:0]   duty,
    output logic                         period_start,
    output logic                         settled
);

    localparam int unsigned MAX = (1 << PWM_BITS) - 1;

    logic [PWM_BITS-1:0] cnt;
    logic                cnt_last;
    logic                step_stb;
    logic [NUM_CH-1:0]   ch_settled;

    // Period is MAX cycles: capture on cnt==0, step on cnt==MAX-1.
    assign cnt_last     = (cnt == PWM_BITS'(MAX - 1));
    assign period_start = en && (cnt == '0);
    assign step_stb     = en && cnt_last;
    assign settled      = &ch_settled;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_last ? '0 : cnt + PWM_BITS'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .capture   (period_start),
            .step      (step_stb),
            .target_in (rgb_in[i]),
            .cnt       (cnt),
            .pwm_out   (pwm_out[i]),
            .duty      (duty[i*PWM_BITS +: PWM_BITS]),
            .settled   (ch_settled[i])
        );
    end

endmodule : rgb_fade_driver

// File: tb/tb_rgb_fade_driver.sv
// Scoreboard bench: per-period expectations queued by stimulus, popped by a monitor on period_start.
module tb_rgb_fade_driver;

    logic        clk = 1'b0;
    logic        rst_a, en_a, ps_a, st_a;
    logic [2:0]  rgb_a, pwm_a;
    logic [11:0] duty_a;
    logic        rst_b, en_b, ps_b, st_b;
    logic [2:0]  rgb_b, pwm_b;
    logic [11:0] duty_b;

    always #5 clk = ~clk;

    rgb_fade_driver #(.PWM_BITS(4), .STEP(5)) dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .en           (en_a),
        .rgb_in       (rgb_a),
        .pwm_out      (pwm_a),
        .duty         (duty_a),
        .period_start (ps_a),
        .settled      (st_a)
    );

    rgb_fade_driver #(.PWM_BITS(4), .STEP(4)) dut_b (
        .clk          (clk),
        .reset        (rst_b),
        .en           (en_b),
        .rgb_in       (rgb_b),
        .pwm_out      (pwm_b),
        .duty         (duty_b),
        .period_start (ps_b),
        .settled      (st_b)
    );

    typedef struct {
        int          dut;
        logic [11:0] duty;
        logic [11:0] hi;
        logic        settled;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Expected state at the end of one period: duties {R,G,B}, high cycles {R,G,B}, settled.
    task automatic expect_period(input int dut, input int dr, input int dg, input int db,
                                 input int hr, input int hg, input int hb, input int st);
        exp_t e;
        e.dut     = dut;
        e.duty    = {4'(dr), 4'(dg), 4'(db)};
        e.hi      = {4'(hr), 4'(hg), 4'(hb)};
        e.settled = 1'(st);
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        int          hi [2][3];
        int          edges [2];
        int          nper [2];
        bit          en_edge [2];
        exp_t        e;
        logic        rst_s, ps_s, st_s;
        logic [2:0]  pwm_s;
        logic [11:0] duty_s;
        for (int d = 0; d < 2; d++) begin
            edges[d] = 0;
            nper[d]  = 0;
            for (int c = 0; c < 3; c++) hi[d][c] = 0;
        end
        forever begin
            @(posedge clk);
            en_edge[0] = en_a && !rst_a;
            en_edge[1] = en_b && !rst_b;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rst_s  = (d != 0) ? rst_b  : rst_a;
                ps_s   = (d != 0) ? ps_b   : ps_a;
                st_s   = (d != 0) ? st_b   : st_a;
                pwm_s  = (d != 0) ? pwm_b  : pwm_a;
                duty_s = (d != 0) ? duty_b : duty_a;
                if (rst_s) begin
                    edges[d] = 0;
                    for (int c = 0; c < 3; c++) hi[d][c] = 0;
                end else begin
                    if (en_edge[d]) begin
                        for (int c = 0; c < 3; c++) hi[d][c] += int'(pwm_s[c]);
                        edges[d]++;
                    end
                    if (ps_s && edges[d] != 0) begin
                        nper[d]++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL dut%0d_period%0d_unexpected: got a period end, expected none",
                                     d, nper[d]);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("dut%0d_period%0d_owner", d, nper[d]), 32'(d), 32'(e.dut));
                            check($sformatf("dut%0d_period%0d_duty", d, nper[d]), 32'(duty_s), 32'(e.duty));
                            check($sformatf("dut%0d_period%0d_high_cycles", d, nper[d]),
                                  32'({4'(hi[d][2]), 4'(hi[d][1]), 4'(hi[d][0])}), 32'(e.hi));
                            check($sformatf("dut%0d_period%0d_length", d, nper[d]), 32'(edges[d]), 32'd15);
                            check($sformatf("dut%0d_period%0d_settled", d, nper[d]), 32'(st_s), 32'(e.settled));
                        end
                        edges[d] = 0;
                        for (int c = 0; c < 3; c++) hi[d][c] = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_a = 1'b1; en_a = 1'b0; rgb_a = 3'b000;
        rst_b = 1'b1; en_b = 1'b0; rgb_b = 3'b000;
        tick(2);
        en_a = 1'b1;
        en_b = 1'b1;
        @(negedge clk);
        check("reset_pwm_a", 32'(pwm_a), 32'd0);
        check("reset_duty_a", 32'(duty_a), 32'd0);
        check("reset_period_start_a", 32'(ps_a), 32'd1);
        check("reset_settled_a", 32'(st_a), 32'd1);
        check("reset_pwm_b", 32'(pwm_b), 32'd0);
        check("reset_duty_b", 32'(duty_b), 32'd0);
        check("reset_settled_b", 32'(st_b), 32'd1);
        @(posedge clk);
        #1;

        // Red ramps up in steps of 5 and saturates.
        rgb_a = 3'b100;
        rst_a = 1'b0;
        expect_period(0,  5, 0, 0,  0, 0, 0, 0);
        expect_period(0, 10, 0, 0,  5, 0, 0, 0);
        expect_period(0, 15, 0, 0, 10, 0, 0, 1);
        tick(45);

        // Switch to blue mid-period: red holds one more period, then cross-fade.
        expect_period(0, 15, 0, 0, 15, 0, 0, 1);
        tick(7);
        rgb_a = 3'b001;
        expect_period(0, 10, 0,  5, 15, 0,  0, 0);
        expect_period(0,  5, 0, 10, 10, 0,  5, 0);
        expect_period(0,  0, 0, 15,  5, 0, 10, 1);
        tick(8);
        tick(45);

        // Freeze at cnt=6 for 20 cycles; the period resumes where it stopped.
        expect_period(0, 0, 0, 15, 0, 0, 15, 1);
        tick(6);
        en_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("freeze%0d_period_start", i), 32'(ps_a), 32'd0);
            check($sformatf("freeze%0d_pwm", i), 32'(pwm_a), 32'b001);
            check($sformatf("freeze%0d_duty", i), 32'(duty_a), 32'h00F);
        end
        @(posedge clk);
        #1;
        en_a = 1'b1;
        tick(9);

        // Asynchronous reset between edges in the middle of a period.
        tick(4);
        @(negedge clk);
        check("pre_reset_pwm", 32'(pwm_a), 32'b001);
        #2;
        rst_a = 1'b1;
        #1;
        check("async_reset_pwm", 32'(pwm_a), 32'd0);
        check("async_reset_duty", 32'(duty_a), 32'd0);
        check("async_reset_cnt_zero", 32'(ps_a), 32'd1);
        check("async_reset_settled", 32'(st_a), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("held_reset_pwm", 32'(pwm_a), 32'd0);
        check("held_reset_duty", 32'(duty_a), 32'd0);
        check("held_reset_cnt_zero", 32'(ps_a), 32'd1);
        expect_period(0, 0, 0, 5, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        tick(15);
        @(negedge clk);
        #1;
        en_a = 1'b0;

        // Green with STEP=4: saturates at 15, then fades back to 0.
        rgb_b = 3'b010;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        expect_period(1, 0,  4, 0, 0,  0, 0, 0);
        expect_period(1, 0,  8, 0, 0,  4, 0, 0);
        expect_period(1, 0, 12, 0, 0,  8, 0, 0);
        expect_period(1, 0, 15, 0, 0, 12, 0, 1);
        tick(46);
        rgb_b = 3'b000;
        expect_period(1, 0, 11, 0, 0, 15, 0, 0);
        expect_period(1, 0,  7, 0, 0, 11, 0, 0);
        expect_period(1, 0,  3, 0, 0,  7, 0, 0);
        expect_period(1, 0,  0, 0, 0,  3, 0, 1);
        tick(74);

        // Noisy colour code; only the value on capture edges (011) matters.
        expect_period(1, 0,  4,  4, 0, 0, 0, 0);
        expect_period(1, 0,  8,  8, 0, 4, 4, 0);
        expect_period(1, 0, 12, 12, 0, 8, 8, 0);
        for (int k = 0; k < 45; k++) begin
            rgb_b = (k % 15 == 0) ? 3'b011 : ((k % 2 != 0) ? 3'b100 : 3'b110);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        en_b = 1'b0;

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rgb_fade_driver
